// File: rtl/enc_pkg.sv
// Shared widths, FSM state encoding and a population-count helper for the
// sequential 16-to-4 priority encoder.
package enc_pkg;

    localparam int unsigned IN_W  = 16;
    localparam int unsigned IDX_W = 4;
    localparam int unsigned CNT_W = 5;

    typedef enum logic [0:0] {
        StIdle  = 1'b0,
        StDrain = 1'b1
    } state_e;

    // Number of set bits in a request vector (0..16).
    function automatic logic [CNT_W-1:0] popcount16(input logic [IN_W-1:0] v);
        logic [CNT_W-1:0] c;
        c = '0;
        for (int i = 0; i < int'(IN_W); i++) begin
            c = c + CNT_W'(v[i]);
        end
        return c;
    endfunction

endpackage

// File: rtl/pri_enc16.sv
// Combinational 16-bit priority encoder: selected index, all-zero flag and
// "at most one bit set" flag. LSB_FIRST picks which end wins.
module pri_enc16
    import enc_pkg::*;
#(
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic [IN_W-1:0]  vec,
    output logic [IDX_W-1:0] idx,
    output logic             zero,
    output logic             single
);

    logic found;

    // Scan in priority order; the first set bit found wins.
    always_comb begin
        idx   = '0;
        found = 1'b0;
        for (int i = 0; i < int'(IN_W); i++) begin
            int pos;
            pos = LSB_FIRST ? i : (int'(IN_W) - 1 - i);
            if (!found && vec[pos]) begin
                idx   = IDX_W'(pos);
                found = 1'b1;
            end
        end
    end

    // Clearing the lowest set bit leaves zero iff at most one bit was set.
    always_comb begin
        zero   = (vec == '0);
        single = ((vec & (vec - IN_W'(1))) == '0);
    end

endmodule

// File: rtl/enc16to4_seq.sv
// Sequential priority encoder: captures a 16-bit request vector and emits one
// beat per set bit (one beat for an all-zero vector) in priority order over a
// valid/ready handshake.
// Optional feature: define ENC16_POPCNT_EN to add out_cnt (beats remaining,
// including the current one).
module enc16to4_seq
    import enc_pkg::*;
#(
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDX_W-1:0] out_idx,
    output logic             out_zero,
    output logic             out_last
`ifdef ENC16_POPCNT_EN
    ,
    output logic [CNT_W-1:0] out_cnt
`endif
);

    state_e           state_q, state_d;
    logic [IN_W-1:0]  pend_q, pend_d;
    logic [IDX_W-1:0] enc_idx;
    logic             enc_zero;
    logic             enc_single;

    pri_enc16 #(
        .LSB_FIRST (LSB_FIRST)
    ) u_pri_enc16 (
        .vec    (pend_q),
        .idx    (enc_idx),
        .zero   (enc_zero),
        .single (enc_single)
    );

    // State and pending-vector registers; reset discards any drain in progress.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            pend_q  <= '0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
        end
    end

    // Next state: capture in IDLE, retire one bit per accepted beat in DRAIN.
    always_comb begin
        state_d = state_q;
        pend_d  = pend_q;
        unique case (state_q)
            StIdle: begin
                if (in_valid && en) begin
                    pend_d  = in;
                    state_d = StDrain;
                end
            end
            StDrain: begin
                // in/in_valid/en are deliberately ignored here.
                if (out_ready) begin
                    pend_d[enc_idx] = 1'b0;
                    if (enc_single) begin
                        state_d = StIdle;
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Outputs depend only on state, so they stay stable while stalled.
    always_comb begin
        in_ready  = en && (state_q == StIdle);
        out_valid = (state_q == StDrain);
        out_idx   = out_valid ? enc_idx : '0;
        out_zero  = out_valid && enc_zero;
        out_last  = out_valid && enc_single;
    end

`ifdef ENC16_POPCNT_EN
    // A zero vector still produces one beat, so it counts as 1.
    always_comb begin
        out_cnt = '0;
        if (out_valid) begin
            out_cnt = enc_zero ? CNT_W'(1) : popcount16(pend_q);
        end
    end
`endif

endmodule

// File: tb/tb_enc16to4_seq.sv
// Self-checking bench for enc16to4_seq. Two instances (LSB-first and
// MSB-first) share all inputs; a list-based model gives expected beat order.
module tb_enc16to4_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [15:0] in = '0;

    logic        in_ready, out_valid, out_zero, out_last;
    logic [3:0]  out_idx;
    logic [4:0]  out_cnt;
    logic        m_in_ready, m_out_valid, m_out_zero, m_out_last;
    logic [3:0]  m_out_idx;
    logic [4:0]  m_out_cnt;

    int checks = 0;
    int errors = 0;

    // Model: set-bit indices in ascending (lsb) and descending (msb) order.
    int exp_l[16];
    int exp_m[16];
    int exp_n;

    always #5 clk = ~clk;

    enc16to4_seq #(.LSB_FIRST(1'b1)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in        (in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_idx   (out_idx),
        .out_zero  (out_zero),
        .out_last  (out_last)
`ifdef ENC16_POPCNT_EN
        ,
        .out_cnt   (out_cnt)
`endif
    );

    enc16to4_seq #(.LSB_FIRST(1'b0)) dut_msb (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .in_valid  (in_valid),
        .in_ready  (m_in_ready),
        .in        (in),
        .out_valid (m_out_valid),
        .out_ready (out_ready),
        .out_idx   (m_out_idx),
        .out_zero  (m_out_zero),
        .out_last  (m_out_last)
`ifdef ENC16_POPCNT_EN
        ,
        .out_cnt   (m_out_cnt)
`endif
    );

`ifndef ENC16_POPCNT_EN
    assign out_cnt   = '0;
    assign m_out_cnt = '0;
`endif

    function automatic void model(input logic [15:0] v);
        exp_n = 0;
        for (int i = 0; i < 16; i++) begin
            if (v[i]) begin
                exp_l[exp_n] = i;
                exp_n++;
            end
        end
        for (int j = 0; j < exp_n; j++) exp_m[j] = exp_l[exp_n - 1 - j];
        if (exp_n == 0) begin
            exp_n    = 1;
            exp_l[0] = 0;
            exp_m[0] = 0;
        end
    endfunction

    function automatic logic [4:0] exp_cnt(input int k);
`ifdef ENC16_POPCNT_EN
        return 5'(exp_n - k);
`else
        return 5'(k - k);
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Capture v and drain it with random stalls; every cycle is compared.
    task automatic run_vector(input logic [15:0] v, input int stall_pct, input string name);
        logic [11:0] obs, exp;
        int k, cyc;
        bit rdy;
        model(v);
        checks++;
        if ({in_ready, m_in_ready} !== 2'b11) begin
            errors++;
            $display("FAIL %s idle_ready got=%b want=11", name, {in_ready, m_in_ready});
        end
        in_valid = 1'b1;
        in       = v;
        tick();
        k   = 0;
        cyc = 0;
        while (k < exp_n && cyc < 400) begin
            rdy       = ($urandom_range(99) >= stall_pct);
            out_ready = rdy;
            exp = {1'b1, 4'(exp_l[k]), (v == 16'h0), (k == exp_n - 1), exp_cnt(k)};
            obs = {out_valid, out_idx, out_zero, out_last, out_cnt};
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL %s lsb_beat%0d got=%h want=%h", name, k, obs, exp);
            end
            exp = {1'b1, 4'(exp_m[k]), (v == 16'h0), (k == exp_n - 1), exp_cnt(k)};
            obs = {m_out_valid, m_out_idx, m_out_zero, m_out_last, m_out_cnt};
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL %s msb_beat%0d got=%h want=%h", name, k, obs, exp);
            end
            // Traffic on the input side during the drain must be ignored.
            in_valid = 1'($urandom);
            in       = 16'($urandom);
            tick();
            in_valid = 1'b0;
            if (rdy) k++;
            cyc++;
        end
        if (cyc >= 400) begin
            errors++;
            $display("FAIL %s timeout beats=%0d want=%0d", name, k, exp_n);
        end
        out_ready = 1'b0;
        checks++;
        if ({out_valid, m_out_valid, in_ready, m_in_ready} !== 4'b0011) begin
            errors++;
            $display("FAIL %s after_drain got=%b want=0011", name,
                     {out_valid, m_out_valid, in_ready, m_in_ready});
        end
    endtask

    task automatic test_reset();
        logic [11:0] obs;
        rst_n = 1'b0;
        en    = 1'b1;
        #1;
        checks++;
        if ({in_ready, m_in_ready} !== 2'b11) begin
            errors++;
            $display("FAIL reset_ready_en1 got=%b want=11", {in_ready, m_in_ready});
        end
        en = 1'b0;
        tick();
        tick();
        checks++;
        if ({in_ready, m_in_ready} !== 2'b00) begin
            errors++;
            $display("FAIL reset_ready_en0 got=%b want=00", {in_ready, m_in_ready});
        end
        obs = {out_valid, out_idx, out_zero, out_last, out_cnt};
        checks++;
        if (obs !== 12'h000) begin
            errors++;
            $display("FAIL reset_outputs got=%h want=000", obs);
        end
        obs = {m_out_valid, m_out_idx, m_out_zero, m_out_last, m_out_cnt};
        checks++;
        if (obs !== 12'h000) begin
            errors++;
            $display("FAIL reset_outputs_msb got=%h want=000", obs);
        end
        en    = 1'b1;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_stall();
        logic [5:0] obs;
        in_valid = 1'b1;
        in       = 16'h0006;
        tick();
        for (int c = 0; c < 4; c++) begin
            out_ready = (c == 3);
            obs = {out_valid, out_idx, out_last};
            checks++;
            if (obs !== {1'b1, 4'd1, 1'b0}) begin
                errors++;
                $display("FAIL stall_hold%0d got=%h want=%h", c, obs, {1'b1, 4'd1, 1'b0});
            end
            obs = {m_out_valid, m_out_idx, m_out_last};
            checks++;
            if (obs !== {1'b1, 4'd2, 1'b0}) begin
                errors++;
                $display("FAIL stall_hold_msb%0d got=%h want=%h", c, obs, {1'b1, 4'd2, 1'b0});
            end
            in_valid = ~in_valid;
            in       = 16'hFFFF;
            tick();
        end
        in_valid = 1'b0;
        obs = {out_valid, out_idx, out_last};
        checks++;
        if (obs !== {1'b1, 4'd2, 1'b1}) begin
            errors++;
            $display("FAIL stall_second got=%h want=%h", obs, {1'b1, 4'd2, 1'b1});
        end
        obs = {m_out_valid, m_out_idx, m_out_last};
        checks++;
        if (obs !== {1'b1, 4'd1, 1'b1}) begin
            errors++;
            $display("FAIL stall_second_msb got=%h want=%h", obs, {1'b1, 4'd1, 1'b1});
        end
        tick();
        out_ready = 1'b0;
        checks++;
        if ({out_valid, m_out_valid} !== 2'b00) begin
            errors++;
            $display("FAIL stall_done got=%b want=00", {out_valid, m_out_valid});
        end
    endtask

    task automatic test_reset_mid();
        model(16'hFFFF);
        in_valid  = 1'b1;
        in        = 16'hFFFF;
        tick();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            checks++;
            if ({out_valid, out_idx} !== {1'b1, 4'(exp_l[k])}) begin
                errors++;
                $display("FAIL rstmid_beat%0d got=%h want=%h", k, {out_valid, out_idx},
                         {1'b1, 4'(exp_l[k])});
            end
            tick();
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({out_valid, m_out_valid, out_cnt} !== 7'b0) begin
            errors++;
            $display("FAIL rstmid_async got=%b want=0", {out_valid, m_out_valid, out_cnt});
        end
        tick();
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            checks++;
            if ({out_valid, m_out_valid, in_ready} !== 3'b001) begin
                errors++;
                $display("FAIL rstmid_stale%0d got=%b want=001", c,
                         {out_valid, m_out_valid, in_ready});
            end
        end
        out_ready = 1'b0;
        run_vector(16'hFFFF, 0, "recapture_ffff");
    endtask

    task automatic test_en();
        en       = 1'b0;
        in_valid = 1'b1;
        in       = 16'h1234;
        #1;
        checks++;
        if ({in_ready, m_in_ready} !== 2'b00) begin
            errors++;
            $display("FAIL en0_ready got=%b want=00", {in_ready, m_in_ready});
        end
        for (int c = 0; c < 3; c++) begin
            tick();
            checks++;
            if ({out_valid, m_out_valid} !== 2'b00) begin
                errors++;
                $display("FAIL en0_nocapture%0d got=%b want=00", c, {out_valid, m_out_valid});
            end
        end
        en = 1'b1;
        in = 16'h0300;
        tick();
        in_valid  = 1'b0;
        en        = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 2; k++) begin
            checks++;
            if ({out_valid, out_idx, m_out_idx} !== {1'b1, 4'(8 + k), 4'(9 - k)}) begin
                errors++;
                $display("FAIL en_mid_beat%0d got=%h want=%h", k, {out_valid, out_idx, m_out_idx},
                         {1'b1, 4'(8 + k), 4'(9 - k)});
            end
            tick();
        end
        out_ready = 1'b0;
        checks++;
        if ({out_valid, in_ready} !== 2'b00) begin
            errors++;
            $display("FAIL en_mid_end got=%b want=00", {out_valid, in_ready});
        end
        en = 1'b1;
        #1;
    endtask

    task automatic test_random();
        logic [15:0] v;
        for (int n = 0; n < 30; n++) begin
            v = 16'($urandom);
            if (n % 3 == 0) v = v & 16'($urandom) & 16'($urandom);
            run_vector(v, $urandom_range(60), "random");
        end
    endtask

    task automatic test_back_to_back();
        for (int n = 0; n < 5; n++) run_vector(16'($urandom), 0, "back_to_back");
    endtask

    initial begin
        test_reset();
        run_vector(16'h0001, 0, "single_0001");
        run_vector(16'h8421, 0, "order_8421");
        run_vector(16'h0000, 0, "zero_0000");
        test_stall();
        test_reset_mid();
        test_en();
        test_random();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/enc16to4_seq.md
ENC16TO4_SEQ -- requirements
Module: enc16to4_seq

Interface
REQ-001 SHALL have parameter: LSB_FIRST, 1, priority order (1: bit 0 highest priority; 0: bit 15 highest).
REQ-002 SHALL have ports (name direction width meaning):
- clk  input  1  sole clock; all state on rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- en  input  1  capture enable; low blocks new vectors but does not stop a drain in progress.
- in_valid  input  1  request vector offered.
- in_ready  output  1  block can capture a vector.
- in  input  16  request vector.
- out_valid  output  1  encoded beat present.
- out_ready  input  1  consumer accepts beat.
- out_idx  output  4  index of selected bit.
- out_zero  output  1  captured vector was all-zero.
- out_last  output  1  final beat for this vector.

Function
REQ-003 SHALL use FSM states IDLE and DRAIN only.
REQ-004 SHALL drive in_ready = en in IDLE and 0 in DRAIN.
REQ-005 SHALL, on in_valid && in_ready, load in into a 16-bit pending register and enter DRAIN on the same edge.
REQ-006 SHALL assert out_valid only in DRAIN; first beat one cycle after the capture edge.
REQ-007 SHALL drive out_idx with the highest-priority set bit of the pending register, per LSB_FIRST.
REQ-008 SHALL assert out_last when the pending register has at most one set bit.
REQ-009 SHALL, on out_valid && out_ready, clear the bit at out_idx; if out_last, return to IDLE on that edge.
REQ-010 SHALL emit, for a captured 16'h0000, exactly one beat with out_zero=1, out_idx=0, out_last=1; out_zero SHALL be 0 otherwise.
REQ-011 SHALL hold out_idx, out_zero and out_last stable while out_valid && !out_ready.
REQ-012 SHALL emit exactly popcount(in) beats (one if zero), in strict priority order, with no duplicates or gaps.
REQ-013 SHALL give a vector-to-vector period of popcount+1 cycles with out_ready held high (one IDLE bubble).
REQ-014 SHALL ignore in and in_valid while in DRAIN; the pending register changes only by REQ-005 and REQ-009.
REQ-015 SHALL let en deassert in DRAIN without effect on the drain in progress.

Reset
REQ-016 SHALL, while rst_n is low, force: state IDLE, pending register 0, out_valid 0, out_idx 0, out_zero 0, out_last 0; in_ready follows en.
REQ-017 SHALL discard any drain interrupted by reset; no stale beats after release.

Configuration
REQ-018 SHALL, with ENC16_POPCNT_EN defined, add output out_cnt[4:0] = beats remaining including the current beat (16..1; 1 for a zero vector), valid when out_valid, 0 in reset.
REQ-019 SHALL, without ENC16_POPCNT_EN, omit port out_cnt and its logic; all other behaviour identical.

Structure
REQ-020 SHALL place IN_W=16, IDX_W=4 and the IDLE/DRAIN state encoding in shared package enc_pkg.
REQ-021 SHALL use one combinational sub-module, pri_enc16 (vector, LSB_FIRST -> idx, zero flag, single-bit flag), instanced on the pending register.

Verification
REQ-022 SHALL cover: in=16'h0001, out_ready=1 -> one beat next cycle, idx=0, last=1, zero=0; in_ready=1 the following cycle.
REQ-023 SHALL cover: in=16'h8421, LSB_FIRST=1 -> idx 0,5,10,15, last on 15; LSB_FIRST=0 -> 15,10,5,0, last on 0.
REQ-024 SHALL cover: in=16'h0000 -> single beat zero=1, idx=0, last=1; out_cnt=1 when ENC16_POPCNT_EN.
REQ-025 SHALL cover: in=16'h0006, out_ready low 3 cycles -> idx=1 held 4 cycles, then idx=2 with last=1; in_valid toggled during DRAIN has no effect.
REQ-026 SHALL cover: in=16'hFFFF, rst_n low after 4 accepted beats -> out_valid 0 immediately, no beats after release; re-capture of 16'hFFFF yields 16 beats, out_cnt 16 down to 1.
REQ-027 SHALL cover: en=0 in IDLE with in_valid=1 -> in_ready=0, no capture; en dropped mid-drain of 16'h0300 -> idx 8,9 still emitted.
